// File: rtl/branch_resolve_unit.sv
// Registered branch-resolution stage for the EX pipeline.
// Evaluates the RV32I conditional branches, computes the target and
// redirect PC, flags mispredicts and holds a multi-cycle flush.
// Saturating performance counters track resolved branches and mispredicts.
module branch_resolve_unit #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 valid_in,
    input  logic                 is_branch,
    input  logic [2:0]           funct3,
    input  logic [WIDTH-1:0]     data_A,
    input  logic [WIDTH-1:0]     data_B,
    input  logic [WIDTH-1:0]     pc,
    input  logic [WIDTH-1:0]     imm,
    input  logic                 pred_taken,
    output logic                 res_valid,
    output logic                 taken,
    output logic [WIDTH-1:0]     target,
    output logic                 mispredict,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic                 illegal,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t               state_q;
    logic [3:0]           flush_cnt_q;
    logic                 flush_q;

    logic                 res_valid_q, res_valid_d;
    logic                 taken_q, taken_d;
    logic [WIDTH-1:0]     target_q, target_d;
    logic                 mispredict_q, mispredict_d;
    logic [WIDTH-1:0]     redirect_q, redirect_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    logic             accept;
    logic             eq, lt_s, lt_u;
    logic             cond;
    logic             is_illegal;
    logic             mis_now;
    logic [WIDTH-1:0] pc_imm, pc_4;

    // Wrong-path instructions during a flush are never accepted.
    assign accept     = valid_in & is_branch & ~stall & (state_q == IDLE);
    assign eq         = (data_A == data_B);
    assign lt_s       = ($signed(data_A) < $signed(data_B));
    assign lt_u       = (data_A < data_B);
    assign is_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
    assign pc_imm     = pc + imm;
    assign pc_4       = pc + WIDTH'(4);
    assign mis_now    = ~is_illegal & (cond ^ pred_taken);

    // Branch condition per funct3; illegal encodings resolve not-taken.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt_s;
            3'b101:  cond = ~lt_s;
            3'b110:  cond = lt_u;
            3'b111:  cond = ~lt_u;
            default: cond = 1'b0;
        endcase
    end

    // Next-state for the result registers and counters.
    always_comb begin
        res_valid_d   = res_valid_q;
        taken_d       = taken_q;
        target_d      = target_q;
        mispredict_d  = mispredict_q;
        redirect_d    = redirect_q;
        illegal_d     = illegal_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (!stall) begin
            res_valid_d  = 1'b0;
            mispredict_d = 1'b0;
            illegal_d    = 1'b0;
            if (accept) begin
                res_valid_d  = 1'b1;
                illegal_d    = is_illegal;
                taken_d      = cond;
                target_d     = pc_imm;
                redirect_d   = cond ? pc_imm : pc_4;
                mispredict_d = mis_now;
                if (!is_illegal && branch_cnt_q != {CNT_WIDTH{1'b1}})
                    branch_cnt_d = branch_cnt_q + 1'b1;
                if (mis_now && mispred_cnt_q != {CNT_WIDTH{1'b1}})
                    mispred_cnt_d = mispred_cnt_q + 1'b1;
            end
        end
    end

    // Result and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q   <= 1'b0;
            taken_q       <= 1'b0;
            target_q      <= '0;
            mispredict_q  <= 1'b0;
            redirect_q    <= '0;
            illegal_q     <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            res_valid_q   <= res_valid_d;
            taken_q       <= taken_d;
            target_q      <= target_d;
            mispredict_q  <= mispredict_d;
            redirect_q    <= redirect_d;
            illegal_q     <= illegal_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Flush FSM: flush rises with the mispredict result and lasts
    // FLUSH_CYCLES non-stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            flush_q     <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (accept && mis_now) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
                        flush_q     <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid   = res_valid_q;
    assign taken       = taken_q;
    assign target      = target_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;
    assign illegal     = illegal_q;
    assign flush       = flush_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          valid_in;
    logic          is_branch;
    logic [2:0]    funct3;
    logic [W-1:0]  data_A, data_B, pc, imm;
    logic          pred_taken;
    logic          res_valid, taken, mispredict, illegal, flush;
    logic [W-1:0]  target, redirect_pc;
    logic [CW-1:0] branch_cnt, mispred_cnt;

    int n_vec = 0;
    int n_err = 0;

    branch_resolve_unit #(.WIDTH(W), .FLUSH_CYCLES(2), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .valid_in(valid_in),
        .is_branch(is_branch), .funct3(funct3), .data_A(data_A), .data_B(data_B),
        .pc(pc), .imm(imm), .pred_taken(pred_taken), .res_valid(res_valid),
        .taken(taken), .target(target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .illegal(illegal), .flush(flush),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one branch for one edge, then drop valid.
    task automatic br(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] p, input logic [W-1:0] i, input logic pr);
        valid_in = 1'b1; is_branch = 1'b1; funct3 = f;
        data_A = a; data_B = b; pc = p; imm = i; pred_taken = pr;
        step();
        valid_in = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out"}, {26'd0, res_valid, taken, mispredict, illegal, flush, 1'b0}, 32'd0);
        chk({tag, ".tgt"}, target, 32'd0);
        chk({tag, ".rpc"}, redirect_pc, 32'd0);
        chk({tag, ".cnt"}, {24'd0, branch_cnt, mispred_cnt}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; valid_in = 1'b0; is_branch = 1'b0; funct3 = 3'b000;
        data_A = '0; data_B = '0; pc = '0; imm = '0; pred_taken = 1'b0;
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Per-type compares, predictions correct
        br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h10, 1'b1);
        chk("blt.taken", taken, 1); chk("blt.vld", res_valid, 1); chk("blt.mis", mispredict, 0);
        chk("blt.tgt", target, 32'h50);
        br(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h10, 1'b0);
        chk("bltu.taken", taken, 0); chk("bltu.rpc", redirect_pc, 32'h44);
        br(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h10, 1'b0);
        chk("bge.taken", taken, 0);
        br(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h10, 1'b1);
        chk("bgeu.taken", taken, 1);
        br(3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 1'b1);
        chk("beq.taken", taken, 1);
        br(3'b001, 32'd5, 32'd5, 32'h40, 32'h10, 1'b0);
        chk("bne.taken", taken, 0); chk("bne.flush", flush, 0);
        step();
        chk("idle.vld", res_valid, 0); chk("idle.taken_hold", taken, 0);
        chk("idle.rpc_hold", redirect_pc, 32'h44); chk("cmp.bcnt", branch_cnt, 6);

        // Taken mispredict, then a branch presented during the flush
        br(3'b000, 32'd3, 32'd3, 32'h100, 32'h20, 1'b0);
        chk("mis.mis", mispredict, 1); chk("mis.rpc", redirect_pc, 32'h120);
        chk("mis.flush1", flush, 1); chk("mis.mcnt", mispred_cnt, 1);
        chk("mis.bcnt", branch_cnt, 7);
        br(3'b000, 32'd3, 32'd3, 32'h300, 32'h20, 1'b1);
        chk("mis.flush2", flush, 1); chk("mis.ign_vld", res_valid, 0);
        chk("mis.ign_bcnt", branch_cnt, 7); chk("mis.ign_rpc", redirect_pc, 32'h120);
        step();
        chk("mis.flush_end", flush, 0); chk("mis.bcnt_end", branch_cnt, 7);

        // Not-taken mispredict with a 3-cycle stall inside the flush
        br(3'b001, 32'd9, 32'd9, 32'h200, 32'h40, 1'b1);
        chk("nt.mis", mispredict, 1); chk("nt.rpc", redirect_pc, 32'h204);
        chk("nt.taken", taken, 0); chk("nt.mcnt", mispred_cnt, 2); chk("nt.flush", flush, 1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall.flush", flush, 1); chk("stall.vld", res_valid, 1);
            chk("stall.mis", mispredict, 1);
            chk("stall.cnt", {24'd0, branch_cnt, mispred_cnt}, {24'd0, 4'd8, 4'd2});
        end
        stall = 1'b0;
        step();
        chk("post.flush2", flush, 1); chk("post.vld", res_valid, 0);
        step();
        chk("post.flush_end", flush, 0);

        // Illegal funct3
        br(3'b010, 32'd1, 32'd1, 32'h80, 32'h8, 1'b1);
        chk("ill.vld", res_valid, 1); chk("ill.ill", illegal, 1); chk("ill.taken", taken, 0);
        chk("ill.mis", mispredict, 0); chk("ill.flush", flush, 0);
        chk("ill.bcnt", branch_cnt, 8); chk("ill.mcnt", mispred_cnt, 2);
        step();
        chk("ill.clear", illegal, 0);

        // Adder wrap-around
        br(3'b000, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h8, 1'b1);
        chk("wrap.tgt", target, 32'h4); chk("wrap.rpc", redirect_pc, 32'h4);
        chk("wrap.bcnt", branch_cnt, 9);

        // Back-to-back accepts saturate branch_cnt
        for (int k = 0; k < 20; k++) br(3'b000, 32'd1, 32'd1, 32'h10, 32'h4, 1'b1);
        chk("sat.bcnt", branch_cnt, 4'hF); chk("sat.mcnt", mispred_cnt, 2);
        chk("sat.vld", res_valid, 1);

        // Asynchronous reset mid-flush
        br(3'b000, 32'd2, 32'd2, 32'h500, 32'h10, 1'b0);
        chk("rst.pre_flush", flush, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        rst_n = 1'b1;
        step();
        chk("rst.flush", flush, 0); chk("rst.bcnt", branch_cnt, 0);
        br(3'b000, 32'd2, 32'd2, 32'h600, 32'h10, 1'b1);
        chk("rst.idle_accept", res_valid, 1); chk("rst.bcnt1", branch_cnt, 1);
        chk("rst.tgt", target, 32'h610);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
